// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side accumulator.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_e;

  // Width of the per-burst sample counter; BURST >= 2 keeps this at least 1.
  function automatic int unsigned cnt_width(input int unsigned burst);
    return $clog2(burst);
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational accumulator step: sum + zero-extended data, optionally clamped.
module sat_add #(
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned DATA_W   = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0]  sum,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  result,
  output logic              carry
);

  logic [ACC_W:0] full;

  // One extra bit catches the carry-out; clamp to all-ones when saturating.
  always_comb begin
    full   = {1'b0, sum} + {{(ACC_W + 1 - DATA_W){1'b0}}, data};
    carry  = full[ACC_W];
    result = full[ACC_W-1:0];
    if (SATURATE && carry) begin
      result = '1;
    end
  end

endmodule

// File: rtl/fifo_read_acc.sv
// Pops samples from an FWFT FIFO, sums BURST of them and presents the result
// with a valid/ready handshake. Saturating or wrapping, with an overflow flag.
module fifo_read_acc
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned BURST    = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              Rclk,
  input  logic              rrst_n,
  input  logic [DATA_W-1:0] Rdata_i,
  input  logic              Rempty_i,
  output logic              Rinc_o,
  output logic [ACC_W-1:0]  Acc_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic              sat_o
);

  localparam int unsigned     CntW    = cnt_width(BURST);
  localparam logic [CntW-1:0] CntLast = CntW'(BURST - 1);

  state_e          state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] add_res;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             carry;
  logic             pop;

  sat_add #(
    .ACC_W   (ACC_W),
    .DATA_W  (DATA_W),
    .SATURATE(SATURATE)
  ) u_sat_add (
    .sum   (sum_q),
    .data  (Rdata_i),
    .result(add_res),
    .carry (carry)
  );

  // Pop strobe: gated by reset so nothing leaves the FIFO in a reset cycle.
  always_comb begin
    pop    = rrst_n && (state_q == ACCUM) && !Rempty_i;
    Rinc_o = pop;
  end

  // Next-state logic: accumulate on pops, hand off the result on the last one.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    unique case (state_q)
      ACCUM: begin
        if (pop) begin
          if (cnt_q == CntLast) begin
            acc_d   = add_res;
            sat_d   = ovf_q | carry;
            valid_d = 1'b1;
            sum_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            sum_d = add_res;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // valid is always set in HOLD, so ready alone completes the handshake.
        if (acc_ready_i) begin
          valid_d = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge Rclk) begin
    if (!rrst_n) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Acc_o       = acc_q;
    acc_valid_o = valid_q;
    sat_o       = sat_q;
  end

endmodule

// File: tb/tb_fifo_read_acc.sv
// Scoreboard bench for fifo_read_acc: a FIFO model feeds the main instance,
// two wide-burst instances cover saturation and wrap.
module tb_fifo_read_acc;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic [15:0] acc;
  logic        valid;
  logic        ready;
  logic        sat;

  logic        aux_rempty;
  logic        aux_ready;
  logic [7:0]  aux_rdata;
  logic        rinc_s, rinc_w;
  logic [9:0]  acc_s, acc_w;
  logic        valid_s, valid_w;
  logic        sat_s, sat_w;

  int          n_checks;
  int          n_pass;
  int          n_pops;
  logic        gap;
  logic [7:0]  fifo_q[$];
  logic [16:0] exp_q[$];
  logic [10:0] exp_s[$];
  logic [10:0] exp_w[$];

  fifo_read_acc u_dut (
    .Rclk       (clk),
    .rrst_n     (rst_n),
    .Rdata_i    (rdata),
    .Rempty_i   (rempty),
    .Rinc_o     (rinc),
    .Acc_o      (acc),
    .acc_valid_o(valid),
    .acc_ready_i(ready),
    .sat_o      (sat)
  );

  fifo_read_acc #(
    .DATA_W  (8),
    .ACC_W   (10),
    .BURST   (8),
    .SATURATE(1'b1)
  ) u_dut_sat (
    .Rclk       (clk),
    .rrst_n     (rst_n),
    .Rdata_i    (aux_rdata),
    .Rempty_i   (aux_rempty),
    .Rinc_o     (rinc_s),
    .Acc_o      (acc_s),
    .acc_valid_o(valid_s),
    .acc_ready_i(aux_ready),
    .sat_o      (sat_s)
  );

  fifo_read_acc #(
    .DATA_W  (8),
    .ACC_W   (10),
    .BURST   (8),
    .SATURATE(1'b0)
  ) u_dut_wrap (
    .Rclk       (clk),
    .rrst_n     (rst_n),
    .Rdata_i    (aux_rdata),
    .Rempty_i   (aux_rempty),
    .Rinc_o     (rinc_w),
    .Acc_o      (acc_w),
    .acc_valid_o(valid_w),
    .acc_ready_i(aux_ready),
    .sat_o      (sat_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  task automatic refresh();
    rempty = gap || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    refresh();
  endtask

  // Returns 2 time units after the edge on which the target pop count is reached.
  task automatic wait_pops(input int target);
    int k;
    k = 0;
    while (n_pops < target && k < 60) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (n_pops < target) check("pop_timeout", n_pops, target);
  endtask

  // FIFO model: the pop strobe seen at the edge removes the head word.
  initial begin
    logic       p;
    logic [7:0] dummy;
    n_pops = 0;
    forever begin
      @(posedge clk);
      p = rinc;
      #1;
      if (p) begin
        if (fifo_q.size() > 0) dummy = fifo_q.pop_front();
        n_pops++;
      end
      refresh();
    end
  end

  // Monitor: each new result (rising valid) is compared with the scoreboard head.
  initial begin
    logic vp, vsp, vwp;
    logic [16:0] e;
    logic [10:0] ea;
    vp = 1'b0; vsp = 1'b0; vwp = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !vp) begin
        if (exp_q.size() == 0) check("main_unexpected_result", int'(acc), -1);
        else begin
          e = exp_q.pop_front();
          check("main_acc", int'(acc), int'(e[15:0]));
          check("main_sat", int'(sat), int'(e[16]));
        end
      end
      if (valid_s && !vsp) begin
        if (exp_s.size() == 0) check("sat_unexpected_result", int'(acc_s), -1);
        else begin
          ea = exp_s.pop_front();
          check("satmode_acc", int'(acc_s), int'(ea[9:0]));
          check("satmode_sat", int'(sat_s), int'(ea[10]));
        end
      end
      if (valid_w && !vwp) begin
        if (exp_w.size() == 0) check("wrap_unexpected_result", int'(acc_w), -1);
        else begin
          ea = exp_w.pop_front();
          check("wrapmode_acc", int'(acc_w), int'(ea[9:0]));
          check("wrapmode_sat", int'(sat_w), int'(ea[10]));
        end
      end
      vp  = valid;
      vsp = valid_s;
      vwp = valid_w;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    gap        = 1'b0;
    ready      = 1'b1;
    aux_rempty = 1'b1;
    aux_ready  = 1'b0;
    aux_rdata  = 8'hFF;
    refresh();
    repeat (2) @(posedge clk);
    #2;
    check("reset_acc", int'(acc), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_sat", int'(sat), 0);
    check("reset_rinc", int'(rinc), 0);
    rst_n = 1'b1;

    // Back-to-back burst 1,2,3,4; the next burst's 1,2 are already queued.
    exp_q.push_back({1'b0, 16'd10});
    push(8'd1); push(8'd2); push(8'd3); push(8'd4); push(8'd1); push(8'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_rinc_burst", int'(rinc), 1);
    end
    @(negedge clk);
    check("t1_hold_rinc", int'(rinc), 0);
    check("t1_hold_valid", int'(valid), 1);

    // Three-cycle gap between samples 2 and 3; keep ready low for the backpressure test.
    exp_q.push_back({1'b0, 16'd10});
    wait_pops(6);
    gap   = 1'b1;
    ready = 1'b0;
    push(8'd3); push(8'd4);
    push(8'd5); push(8'd5); push(8'd5); push(8'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_gap_rinc", int'(rinc), 0);
    end
    check("t2_gap_pops", n_pops, 6);
    @(posedge clk);
    #2;
    gap = 1'b0;
    refresh();

    // Backpressure for five cycles with data waiting, then burst of 5s.
    exp_q.push_back({1'b0, 16'd20});
    wait_pops(8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_bp_rinc", int'(rinc), 0);
      check("t3_bp_acc", int'(acc), 10);
      check("t3_bp_valid", int'(valid), 1);
    end
    @(posedge clk);
    #2;
    ready = 1'b1;
    wait_pops(12);

    // Reset after two pops of 9; the 9s must not leak into the next result.
    exp_q.push_back({1'b0, 16'd20});
    push(8'd9); push(8'd9);
    wait_pops(14);
    rst_n = 1'b0;
    push(8'd5); push(8'd5); push(8'd5); push(8'd5);
    @(negedge clk);
    check("t5_reset_rinc", int'(rinc), 0);
    @(posedge clk);
    #2;
    check("t5_reset_acc", int'(acc), 0);
    check("t5_reset_valid", int'(valid), 0);
    check("t5_reset_sat", int'(sat), 0);
    check("t5_reset_nopop", n_pops, 14);
    rst_n = 1'b1;
    ready = 1'b0;
    wait_pops(18);

    // Reset while a result is held.
    @(negedge clk);
    check("t6_hold_valid", int'(valid), 1);
    check("t6_hold_rinc", int'(rinc), 0);
    push(8'd7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check("t6_reset_valid", int'(valid), 0);
    check("t6_reset_acc", int'(acc), 0);
    rst_n = 1'b1;
    ready = 1'b1;
    exp_q.push_back({1'b0, 16'd10});
    push(8'd1); push(8'd1); push(8'd1);
    @(negedge clk);
    check("t6_resume_rinc", int'(rinc), 1);
    @(posedge clk);
    #2;
    check("t6_resume_pop", n_pops, 19);
    wait_pops(22);

    // Eight 0xFF samples into 10-bit accumulators: 2040 clamps to 1023 or wraps to 1016.
    exp_s.push_back({1'b1, 10'd1023});
    exp_w.push_back({1'b1, 10'd1016});
    aux_rempty = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    check("t4_hold_rinc_sat", int'(rinc_s), 0);
    check("t4_hold_rinc_wrap", int'(rinc_w), 0);
    check("t4_valid_sat", int'(valid_s), 1);

    repeat (3) @(negedge clk);
    check("main_results_left", exp_q.size(), 0);
    check("sat_results_left", exp_s.size(), 0);
    check("wrap_results_left", exp_w.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
